// File: rtl/accumulator_memory.sv
// rtl/accumulator_memory.sv - shared LIFO operand store answering FETCH/SEND on the accumulator bus
module accumulator_memory #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 0,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [1:0]        op,
    inout  wire  [DATA_W-1:0] data,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [CNT_W-1:0]  count,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              underflow,
    output logic              overflow,
    output logic              protocol_err
);
    localparam logic [1:0] OP_FETCH = 2'b01;
    localparam logic [1:0] OP_SEND  = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state, state_next;
    logic [7:0]          timer, timer_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    pending;
    logic [DATA_W-1:0]   rsp_reg;
    logic                resp_fetch;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                is_fetch, is_send, empty, full;
    logic                accept_fetch, accept_send, do_load, proto_hit, push;
    logic [DATA_W-1:0]   push_word;
    logic [AW-1:0]       top_idx, push_idx;

    assign is_fetch   = (op == OP_FETCH);
    assign is_send    = (op == OP_SEND);
    assign empty      = (cnt == '0);
    assign full       = (cnt == CNT_W'(DEPTH));
    assign top_idx    = AW'(cnt - CNT_W'(1));
    assign push_idx   = AW'(cnt);
    assign load_ready = (state == S_IDLE) && !is_fetch && !is_send;

    always_comb begin
        state_next   = state;
        timer_next   = timer;
        accept_fetch = 1'b0;
        accept_send  = 1'b0;
        do_load      = 1'b0;
        proto_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_fetch || is_send) begin
                    accept_fetch = is_fetch;
                    accept_send  = is_send;
                    if (LATENCY == 0) begin
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                        timer_next = 8'(LATENCY);
                    end
                end else begin
                    do_load = load_valid && load_ready;
                end
            end
            S_WAIT: begin
                proto_hit = is_fetch || is_send;
                if (timer <= 8'd1) begin
                    state_next = S_RESP;
                end else begin
                    timer_next = timer - 8'd1;
                end
            end
            default: begin
                proto_hit  = is_fetch || is_send;
                state_next = S_IDLE;
            end
        endcase
    end

    // A bus SEND and a preload share one push path; the command always has priority.
    assign push      = accept_send || do_load;
    assign push_word = accept_send ? data : load_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            cnt          <= '0;
            pending      <= '0;
            rsp_reg      <= '0;
            resp_fetch   <= 1'b0;
            underflow    <= 1'b0;
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            if (accept_fetch) begin
                resp_fetch <= 1'b1;
                pending    <= pending + CNT_W'(1);
                if (empty) begin
                    rsp_reg   <= '0;
                    underflow <= 1'b1;
                end else begin
                    rsp_reg <= mem[top_idx];
                    cnt     <= cnt - CNT_W'(1);
                end
            end
            if (accept_send) begin
                resp_fetch <= 1'b0;
                pending    <= (pending < CNT_W'(2)) ? '0 : pending - CNT_W'(2);
            end
            if (push) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (proto_hit) begin
                protocol_err <= 1'b1;
            end
        end
    end

    // Stack contents are deliberately left unreset; only the count defines validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[push_idx] <= push_word;
        end
    end

    assign op     = (state == S_RESP) ? OP_END : 2'bzz;
    assign data   = (state == S_RESP && resp_fetch) ? rsp_reg : {DATA_W{1'bz}};
    assign count  = cnt;
    assign done   = (cnt == CNT_W'(1)) && (pending == '0) && (state == S_IDLE);
    assign result = mem[0];
endmodule

// File: tb/tb_accumulator_memory.sv
// tb/tb_accumulator_memory.sv - scoreboard bench for accumulator_memory with a stack reference model
module tb_accumulator_memory;
    localparam int D0 = 4;
    localparam int L0 = 0;
    localparam int D1 = 16;
    localparam int L1 = 3;
    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] FETCH = 2'b01;
    localparam logic [1:0] SEND  = 2'b10;
    localparam logic [1:0] ENDOP = 2'b11;

    typedef struct packed {
        logic        fetch;
        logic [31:0] val;
        logic [31:0] due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst  [2];
    logic        lv   [2];
    logic [31:0] ld   [2];
    logic        den  [2];
    logic [1:0]  dop  [2];
    logic [31:0] ddat [2];

    wire [1:0]  op0, op1;
    wire [31:0] data0, data1;
    assign op0   = den[0] ? dop[0] : 2'bzz;
    assign op1   = den[1] ? dop[1] : 2'bzz;
    assign data0 = (den[0] && dop[0] == SEND) ? ddat[0] : 32'hzzzz_zzzz;
    assign data1 = (den[1] && dop[1] == SEND) ? ddat[1] : 32'hzzzz_zzzz;

    logic        lr0, lr1, done0, done1, uf0, uf1, of0, of1, pe0, pe1;
    logic [2:0]  cnt0;
    logic [4:0]  cnt1;
    logic [31:0] res0, res1;

    accumulator_memory #(.DATA_W(32), .DEPTH(D0), .LATENCY(L0)) u0 (
        .clk(clk), .reset(rst[0]), .op(op0), .data(data0),
        .load_valid(lv[0]), .load_data(ld[0]), .load_ready(lr0),
        .count(cnt0), .done(done0), .result(res0),
        .underflow(uf0), .overflow(of0), .protocol_err(pe0)
    );

    accumulator_memory #(.DATA_W(32), .DEPTH(D1), .LATENCY(L1)) u1 (
        .clk(clk), .reset(rst[1]), .op(op1), .data(data1),
        .load_valid(lv[1]), .load_data(ld[1]), .load_ready(lr1),
        .count(cnt1), .done(done1), .result(res1),
        .underflow(uf1), .overflow(of1), .protocol_err(pe1)
    );

    // Reference model: an array stack per instance plus flag/pending bookkeeping
    logic [31:0] mstk [2][16];
    int          mcnt  [2];
    int          mpend [2];
    bit          muf [2], mof [2], mpe [2];
    int          dep [2];
    int          lat [2];
    exp_t        q0[$], q1[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] g_op(input int k);
        return (k == 0) ? op0 : op1;
    endfunction

    function automatic logic [31:0] g_data(input int k);
        return (k == 0) ? data0 : data1;
    endfunction

    function automatic logic g_lr(input int k);
        return (k == 0) ? lr0 : lr1;
    endfunction

    task automatic model_reset(input int k);
        mcnt[k] = 0; mpend[k] = 0;
        muf[k] = 0; mof[k] = 0; mpe[k] = 0;
        if (k == 0) q0.delete(); else q1.delete();
    endtask

    task automatic model_push(input int k, input logic [31:0] w);
        if (mcnt[k] == dep[k]) begin
            mof[k] = 1;
        end else begin
            mstk[k][mcnt[k]] = w;
            mcnt[k]++;
        end
    endtask

    task automatic check_state(input int k, input string tag);
        logic [31:0] c, u, o, p, d;
        if (k == 0) begin
            c = 32'(cnt0); u = 32'(uf0); o = 32'(of0); p = 32'(pe0); d = 32'(done0);
        end else begin
            c = 32'(cnt1); u = 32'(uf1); o = 32'(of1); p = 32'(pe1); d = 32'(done1);
        end
        chk({tag, "_count"}, c, 32'(mcnt[k]));
        chk({tag, "_underflow"}, u, 32'(muf[k]));
        chk({tag, "_overflow"}, o, 32'(mof[k]));
        chk({tag, "_protocol_err"}, p, 32'(mpe[k]));
        chk({tag, "_done"}, d, 32'(mcnt[k] == 1 && mpend[k] == 0));
    endtask

    // Called at #1 after a rising edge while the DUT is idle; returns likewise.
    task automatic issue(input int k, input logic [1:0] cmd, input logic [31:0] w,
                         input bit expect_lr_low, output logic [31:0] got);
        exp_t e;
        e.fetch = (cmd == FETCH);
        e.val   = 32'd0;
        e.due   = cyc + 1 + lat[k];
        if (cmd == FETCH) begin
            if (mcnt[k] == 0) begin
                muf[k] = 1;
            end else begin
                mcnt[k]--;
                e.val = mstk[k][mcnt[k]];
            end
            mpend[k]++;
        end else begin
            mpend[k] = (mpend[k] < 2) ? 0 : mpend[k] - 2;
            model_push(k, w);
        end
        got = e.val;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        dop[k] = cmd; ddat[k] = w; den[k] = 1'b1;
        if (expect_lr_low) begin
            @(negedge clk);
            chk($sformatf("load_ready_low_on_cmd_u%0d", k), 32'(g_lr(k)), 32'd0);
        end
        @(posedge clk); #1;
        den[k] = 1'b0; dop[k] = NOP;
        repeat (lat[k] + 1) @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [31:0] w);
        lv[k] = 1'b1; ld[k] = w;
        @(negedge clk);
        chk($sformatf("load_ready_u%0d", k), 32'(g_lr(k)), 32'd1);
        @(posedge clk); #1;
        lv[k] = 1'b0;
        model_push(k, w);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   sz;
        for (int k = 0; k < 2; k++) begin
            if (!rst[k] && g_op(k) == ENDOP) begin
                sz = (k == 0) ? q0.size() : q1.size();
                if (sz == 0) begin
                    chk($sformatf("unexpected_end_u%0d", k), 32'd1, 32'd0);
                end else begin
                    if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
                    chk($sformatf("end_cycle_u%0d", k), cyc, e.due);
                    if (e.fetch) chk($sformatf("fetch_data_u%0d", k), g_data(k), e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, x, w;
        int          r, gap;
        dep[0] = D0; dep[1] = D1; lat[0] = L0; lat[1] = L1;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; lv[k] = 1'b0; ld[k] = '0;
            den[k] = 1'b0; dop[k] = NOP; ddat[k] = '0;
            model_reset(k);
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        check_state(0, "reset_u0");
        check_state(1, "reset_u1");
        chk("reset_op_released", 32'(op0 == ENDOP), 32'd0);

        // Preload then FETCH, FETCH, SEND(sum) until one word remains
        load(0, 32'd3); load(0, 32'd5); load(0, 32'd7); load(0, 32'd9);
        while (mcnt[0] > 1) begin
            issue(0, FETCH, 32'd0, 1'b0, a);
            issue(0, FETCH, 32'd0, 1'b0, b);
            issue(0, SEND, a + b, 1'b0, x);
        end
        check_state(0, "preload");
        chk("preload_result", res0, 32'd24);

        // Overflow on a full stack, then a load colliding with a FETCH
        for (int i = 0; i < 3; i++) load(0, $urandom);
        issue(0, SEND, 32'hDEAD, 1'b0, x);
        check_state(0, "overflow");
        issue(0, FETCH, 32'd0, 1'b0, x);
        w = $urandom;
        lv[0] = 1'b1; ld[0] = w;
        issue(0, FETCH, 32'd0, 1'b1, x);
        load(0, w);
        check_state(0, "collision");
        issue(0, FETCH, 32'd0, 1'b0, x);

        // Underflow and latency on the LATENCY=3 instance
        issue(1, FETCH, 32'd0, 1'b0, x);
        check_state(1, "underflow");
        load(1, $urandom);
        issue(1, FETCH, 32'd0, 1'b0, x);

        // FETCH during WAIT is ignored but flagged
        load(1, $urandom);
        fork
            issue(1, FETCH, 32'd0, 1'b0, x);
            begin
                repeat (2) @(posedge clk);
                #1;
                dop[1] = FETCH; den[1] = 1'b1;
                @(posedge clk); #1;
                den[1] = 1'b0; dop[1] = NOP;
                mpe[1] = 1;
            end
        join
        check_state(1, "protocol");

        // Reset in the middle of WAIT aborts the transaction
        load(1, $urandom);
        fork
            issue(1, FETCH, 32'd0, 1'b0, x);
            begin
                repeat (2) @(posedge clk);
                #1;
                rst[1] = 1'b1;
                model_reset(1);
                #1;
                chk("abort_op_released", 32'(op1 == ENDOP), 32'd0);
                chk("abort_count_async", 32'(cnt1), 32'd0);
                repeat (4) @(posedge clk);
                #1;
                rst[1] = 1'b0;
            end
        join
        check_state(1, "after_reset");
        load(1, $urandom); load(1, $urandom);
        issue(1, FETCH, 32'd0, 1'b0, x);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 5);
            w = $urandom;
            if (r < 2)      load(1, w);
            else if (r < 4) issue(1, FETCH, 32'd0, 1'b0, x);
            else            issue(1, SEND, w, 1'b0, x);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
        check_state(1, "random");

        repeat (3) @(posedge clk);
        #1;
        chk("outstanding_end_u0", 32'(q0.size()), 32'd0);
        chk("outstanding_end_u1", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
